// File: rtl/mpsoc_sysid_ctrl.sv
// System-identification and boot-control Avalon-MM slave: ID/timestamp/config words,
// 64-bit uptime with coherent high-word shadow, test-and-set lock, scratch words, CPU release lines.
module mpsoc_sysid_ctrl #(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int          NUM_CPUS    = 4,
  parameter int          NUM_SCRATCH = 4,
  parameter logic [15:0] RELEASE_RST = 16'h0001
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [3:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  input  logic [3:0]          byteenable,
  output logic [31:0]         readdata,
  output logic                readdatavalid,
  output logic [NUM_CPUS-1:0] cpu_release
);

  localparam logic [31:0] CONFIG_WORD = {16'h0002, 8'(NUM_SCRATCH), 8'(NUM_CPUS)};

  generate
    if (NUM_CPUS < 1 || NUM_CPUS > 16) begin : g_bad_cpus
      $error("NUM_CPUS must be in 1..16");
    end
    if (NUM_SCRATCH < 0 || NUM_SCRATCH > 8) begin : g_bad_scratch
      $error("NUM_SCRATCH must be in 0..8");
    end
  endgenerate

  logic [63:0]         uptime;
  logic [31:0]         shadow;
  logic                lock;
  logic [31:0]         scratch [8];
  logic [NUM_CPUS-1:0] release_q;

  logic        do_read;
  logic        do_write;
  logic        scratch_hit;
  logic [31:0] rd_mux;
  logic [31:0] release_merged;
  logic [31:0] scratch_merged;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // A simultaneous read is dropped entirely so it has no lock/shadow side effects.
  assign do_write       = write;
  assign do_read        = read & ~write;
  assign scratch_hit    = address[3] && ({29'd0, address[2:0]} < 32'(NUM_SCRATCH));
  assign release_merged = merge_bytes(32'(release_q), writedata, byteenable);
  assign scratch_merged = merge_bytes(scratch[address[2:0]], writedata, byteenable);
  assign cpu_release    = release_q;

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      4'd0: rd_mux = SYSTEM_ID;
      4'd1: rd_mux = TIMESTAMP;
      4'd2: rd_mux = CONFIG_WORD;
      4'd3: rd_mux = uptime[31:0];
      4'd4: rd_mux = shadow;
      4'd5: rd_mux = 32'(release_q);
      4'd6: rd_mux = {31'd0, lock};
      default: begin
        if (scratch_hit) rd_mux = scratch[address[2:0]];
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= 64'd0;
    end else begin
      uptime <= uptime + 64'd1;
    end
  end

  // Shadow is loaded on the same edge the low word is sampled, keeping LO/HI coherent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= 32'd0;
      lock   <= 1'b0;
    end else if (do_write) begin
      if (address == 4'd6 && byteenable[0]) lock <= writedata[0];
    end else if (do_read) begin
      if (address == 4'd3) shadow <= uptime[63:32];
      if (address == 4'd6) lock   <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      release_q <= RELEASE_RST[NUM_CPUS-1:0];
      for (int i = 0; i < 8; i++) scratch[i] <= 32'd0;
    end else if (do_write) begin
      if (address == 4'd5) release_q <= release_merged[NUM_CPUS-1:0];
      if (scratch_hit) scratch[address[2:0]] <= scratch_merged;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'd0;
      readdatavalid <= 1'b0;
    end else begin
      readdata      <= do_read ? rd_mux : 32'd0;
      readdatavalid <= do_read;
    end
  end

endmodule

// File: tb/tb_mpsoc_sysid_ctrl.sv
// Directed self-checking bench for mpsoc_sysid_ctrl using immediate assertions.
module tb_mpsoc_sysid_ctrl;

  logic        clock;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [3:0]  cpu_release;

  int compared;
  int mismatched;

  mpsoc_sysid_ctrl #(
    .SYSTEM_ID  (32'h1234_5678),
    .TIMESTAMP  (32'h6250_1A3A),
    .NUM_CPUS   (4),
    .NUM_SCRATCH(4),
    .RELEASE_RST(16'h0001)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .cpu_release  (cpu_release)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle read: strobe for one cycle, sample response at the following negedge.
  task automatic do_read(input logic [3:0] a, output logic [31:0] data, output logic valid);
    @(negedge clock);
    read    = 1'b1;
    address = a;
    @(negedge clock);
    read  = 1'b0;
    data  = readdata;
    valid = readdatavalid;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    write      = 1'b1;
    address    = a;
    writedata  = d;
    byteenable = be;
    @(negedge clock);
    write      = 1'b0;
    byteenable = 4'h0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] expected);
    logic [31:0] d;
    logic        v;
    do_read(a, d, v);
    check({tag, "_valid"}, 32'(v), 32'd1);
    check(tag, d, expected);
  endtask

  logic [31:0] exp_b2b [8];
  int          pulses;

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    address    = 4'd0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
    byteenable = 4'h0;

    repeat (3) @(negedge clock);
    check("rst_valid", 32'(readdatavalid), 32'd0);
    check("rst_rdata", readdata, 32'd0);
    check("rst_release", 32'(cpu_release), 32'h1);
    reset_n = 1'b1;

    read_check("sysid", 4'd0, 32'h1234_5678);
    read_check("tstamp", 4'd1, 32'h6250_1A3A);
    read_check("config", 4'd2, 32'h0002_0404);
    read_check("reserved", 4'd7, 32'h0);
    @(negedge clock);
    check("idle_valid", 32'(readdatavalid), 32'd0);
    check("idle_rdata", readdata, 32'd0);

    // Preload the counter just below a low-word carry, then read LO and later HI.
    @(negedge clock);
    force dut.uptime = 64'h0000_0001_FFFF_FFFF;
    read    = 1'b1;
    address = 4'd3;
    @(negedge clock);
    release dut.uptime;
    read = 1'b0;
    check("uptime_lo_valid", 32'(readdatavalid), 32'd1);
    check("uptime_lo", readdata, 32'hFFFF_FFFF);
    repeat (10) @(negedge clock);
    read_check("uptime_hi", 4'd4, 32'h0000_0001);

    read_check("lock_rd1", 4'd6, 32'h0);
    read_check("lock_rd2", 4'd6, 32'h1);
    do_write(4'd6, 32'h0, 4'h1);
    read_check("lock_rd3", 4'd6, 32'h0);
    do_write(4'd6, 32'h0, 4'hE);
    read_check("lock_be0_ignored", 4'd6, 32'h1);

    do_write(4'd10, 32'hAABB_CCDD, 4'b0101);
    read_check("scratch2_be", 4'd10, 32'h00BB_00DD);
    do_write(4'd12, 32'hFFFF_FFFF, 4'hF);
    read_check("unmapped12", 4'd12, 32'h0);

    do_write(4'd5, 32'hFFFF_FFFF, 4'hF);
    check("release_out", 32'(cpu_release), 32'hF);
    read_check("release_rd", 4'd5, 32'h0000_000F);
    do_write(4'd5, 32'h0000_0000, 4'hE);
    read_check("release_be", 4'd5, 32'h0000_000F);

    // Reset arrives right after a read is accepted: the response must vanish.
    @(negedge clock);
    read    = 1'b1;
    address = 4'd0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(readdatavalid), 32'd0);
    check("midrst_rdata", readdata, 32'd0);
    check("midrst_release", 32'(cpu_release), 32'h1);
    read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("postrst_valid", 32'(readdatavalid), 32'd0);

    @(negedge clock);
    read       = 1'b1;
    write      = 1'b1;
    address    = 4'd8;
    writedata  = 32'h5A5A_5A5A;
    byteenable = 4'hF;
    @(negedge clock);
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'h0;
    check("rw_no_valid", 32'(readdatavalid), 32'd0);
    read_check("rw_write_applied", 4'd8, 32'h5A5A_5A5A);

    // Full-rate reads of words 0..7; counter is below 2^32 after reset so the shadow reads 0.
    exp_b2b[0] = 32'h1234_5678;
    exp_b2b[1] = 32'h6250_1A3A;
    exp_b2b[2] = 32'h0002_0404;
    exp_b2b[3] = 32'h0;
    exp_b2b[4] = 32'h0;
    exp_b2b[5] = 32'h1;
    exp_b2b[6] = 32'h0;
    exp_b2b[7] = 32'h0;
    pulses = 0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clock);
      if (i > 0) begin
        if (readdatavalid) pulses++;
        if (i != 4) check($sformatf("b2b_data%0d", i - 1), readdata, exp_b2b[i-1]);
      end
      if (i < 8) begin
        read    = 1'b1;
        address = 4'(i);
      end else begin
        read = 1'b0;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd8);
    read_check("lock_after_b2b", 4'd6, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
